// File: rtl/shs_pkg.sv
// rtl/shs_pkg.sv - security state encodings and default climate/timing thresholds
package shs_pkg;

  localparam int SEC_W = 2;

  typedef enum logic [SEC_W-1:0] {
    SEC_DISARMED = 2'd0,
    SEC_ARMED    = 2'd1,
    SEC_ENTRY    = 2'd2,
    SEC_ALARM    = 2'd3
  } sec_state_e;

  localparam int DEF_FAN_ON         = 25;
  localparam int DEF_AC_ON          = 28;
  localparam int DEF_HYST           = 2;
  localparam int DEF_DEB_CYCLES     = 4;
  localparam int DEF_AC_MIN_CYCLES  = 16;
  localparam int DEF_ENTRY_DELAY    = 32;

endpackage

// File: rtl/shs_zone_ctrl_if.sv
// rtl/shs_zone_ctrl_if.sv - sensor inputs and actuator outputs of the zone controller
interface shs_zone_ctrl_if #(
  parameter int N_ZONES = 4,
  parameter int TEMP_W  = 8
);
  import shs_pkg::*;

  logic [N_ZONES*TEMP_W-1:0] temperature;
  logic [N_ZONES-1:0]        light_sensor;
  logic [N_ZONES-1:0]        motion_sensor;
  logic                      gas_sensor;
  logic                      door_sensor;
  logic                      rain_sensor;
  logic                      arm;
  logic                      disarm;
  logic                      alarm_ack;
  logic [N_ZONES-1:0]        fan;
  logic [N_ZONES-1:0]        ac;
  logic [N_ZONES-1:0]        room_light;
  logic                      exhaust_fan;
  logic                      window_closer;
  logic                      door_lock;
  logic                      security_alarm;
  logic [SEC_W-1:0]          alarm_state;

  modport master (
    output temperature, light_sensor, motion_sensor, gas_sensor, door_sensor,
           rain_sensor, arm, disarm, alarm_ack,
    input  fan, ac, room_light, exhaust_fan, window_closer, door_lock,
           security_alarm, alarm_state
  );

  modport slave (
    input  temperature, light_sensor, motion_sensor, gas_sensor, door_sensor,
           rain_sensor, arm, disarm, alarm_ack,
    output fan, ac, room_light, exhaust_fan, window_closer, door_lock,
           security_alarm, alarm_state
  );

endinterface

// File: rtl/shs_debounce.sv
// rtl/shs_debounce.sv - per-bit debouncer; value flips after CYCLES consecutive differing samples
module shs_debounce #(
  parameter int               WIDTH   = 1,
  parameter int               CYCLES  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0]         db_q, db_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (raw_i[i] != db_q[i]) begin
        if (cnt_q[i] + CW'(1) == CW'(CYCLES)) begin
          db_d[i] = raw_i[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= RST_VAL;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/shs_zone_ctrl.sv
// rtl/shs_zone_ctrl.sv - multi-zone climate/light control, gas latch and arm/entry/alarm FSM
module shs_zone_ctrl
  import shs_pkg::*;
#(
  parameter int N_ZONES       = 4,
  parameter int TEMP_W        = 8,
  parameter int FAN_ON        = DEF_FAN_ON,
  parameter int AC_ON         = DEF_AC_ON,
  parameter int HYST          = DEF_HYST,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int AC_MIN_CYCLES = DEF_AC_MIN_CYCLES,
  parameter int ENTRY_DELAY   = DEF_ENTRY_DELAY
) (
  input  logic            clk,
  input  logic            reset,
  shs_zone_ctrl_if.slave  bus
);

  if (HYST > FAN_ON) begin : g_hyst_check
    $error("HYST must not exceed FAN_ON");
  end

  localparam int SW = 2*N_ZONES + 3;
  localparam int DW = $clog2(AC_MIN_CYCLES + 1);
  localparam int EW = $clog2(ENTRY_DELAY + 1);
  localparam logic [SW-1:0]     DB_RST  = {{(N_ZONES+3){1'b0}}, {N_ZONES{1'b1}}};
  localparam logic [TEMP_W-1:0] FAN_SET = TEMP_W'(FAN_ON);
  localparam logic [TEMP_W-1:0] FAN_CLR = TEMP_W'(FAN_ON - HYST);
  localparam logic [TEMP_W-1:0] AC_SET  = TEMP_W'(AC_ON);
  localparam logic [TEMP_W-1:0] AC_CLR  = TEMP_W'(AC_ON - HYST);

  // Light bits come out of reset "bright" so no lamp switches on at power-up
  logic [SW-1:0]      raw, db;
  logic [N_ZONES-1:0] light_db, motion_db;
  logic               gas_db, door_db, rain_db;

  assign raw = {bus.rain_sensor, bus.door_sensor, bus.gas_sensor,
                bus.motion_sensor, bus.light_sensor};

  shs_debounce #(.WIDTH(SW), .CYCLES(DEB_CYCLES), .RST_VAL(DB_RST)) u_debounce (
    .clk   (clk),
    .rst_n (reset),
    .raw_i (raw),
    .db_o  (db)
  );

  assign light_db  = db[N_ZONES-1:0];
  assign motion_db = db[2*N_ZONES-1:N_ZONES];
  assign gas_db    = db[2*N_ZONES];
  assign door_db   = db[2*N_ZONES+1];
  assign rain_db   = db[2*N_ZONES+2];

  logic [N_ZONES-1:0] fan_w, ac_w;

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    logic [TEMP_W-1:0] temp;
    logic              fan_q, fan_d, ac_q, ac_d, ac_req;
    logic [DW-1:0]     dwell_q, dwell_d;

    assign temp = bus.temperature[z*TEMP_W +: TEMP_W];

    // The AC request is recomputed every cycle; the dwell timer only gates when it may apply
    always_comb begin
      fan_d   = fan_q;
      ac_req  = ac_q;
      ac_d    = ac_q;
      dwell_d = dwell_q;
      if (temp > FAN_SET)       fan_d = 1'b1;
      else if (temp <= FAN_CLR) fan_d = 1'b0;
      if (temp > AC_SET)        ac_req = 1'b1;
      else if (temp <= AC_CLR)  ac_req = 1'b0;
      if (dwell_q != '0) begin
        dwell_d = dwell_q - DW'(1);
      end else if (ac_req != ac_q) begin
        ac_d    = ac_req;
        dwell_d = DW'(AC_MIN_CYCLES - 1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        fan_q   <= 1'b0;
        ac_q    <= 1'b0;
        dwell_q <= '0;
      end else begin
        fan_q   <= fan_d;
        ac_q    <= ac_d;
        dwell_q <= dwell_d;
      end
    end

    assign fan_w[z] = fan_q;
    assign ac_w[z]  = ac_q;
  end

  sec_state_e         state_q, state_d;
  logic [EW-1:0]      entry_q, entry_d;
  logic               latch_q, latch_d;
  logic               window_q, lock_q, alarm_q;
  logic [N_ZONES-1:0] room_light_q;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (bus.disarm) begin
      state_d = SEC_DISARMED;
    end else begin
      case (state_q)
        SEC_DISARMED: if (bus.arm) state_d = SEC_ARMED;
        SEC_ARMED: begin
          if ((|motion_db) || door_db) begin
            state_d = SEC_ENTRY;
            entry_d = EW'(ENTRY_DELAY - 1);
          end
        end
        SEC_ENTRY: begin
          if (entry_q == '0) state_d = SEC_ALARM;
          else               entry_d = entry_q - EW'(1);
        end
        default: state_d = state_q;
      endcase
    end
  end

  // An acknowledge cannot clear the latch while gas is still present
  assign latch_d = gas_db | (latch_q & ~bus.alarm_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEC_DISARMED;
      entry_q      <= '0;
      latch_q      <= 1'b0;
      window_q     <= 1'b0;
      lock_q       <= 1'b0;
      alarm_q      <= 1'b0;
      room_light_q <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      latch_q      <= latch_d;
      window_q     <= rain_db & ~latch_d;
      lock_q       <= door_db | (state_d != SEC_DISARMED);
      alarm_q      <= (state_d == SEC_ALARM);
      room_light_q <= ~light_db;
    end
  end

  assign bus.fan            = fan_w;
  assign bus.ac             = ac_w;
  assign bus.room_light     = room_light_q;
  assign bus.exhaust_fan    = latch_q;
  assign bus.window_closer  = window_q;
  assign bus.door_lock      = lock_q;
  assign bus.security_alarm = alarm_q;
  assign bus.alarm_state    = state_q;

endmodule
